mem_port_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the IF stage (read-only fetch) and the MEM stage (lw/sw) of the 5-stage pipeline. It sequences each access through a fixed-latency memory and returns data with a one-cycle done pulse. It produces per-requester stall signals that feed the PC stall and pipeline-register stall/clear logic. At most one access is outstanding.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/arb_pick2.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the IF/MEM memory-port arbiter.
//   - arb_state_t : sequencing FSM states (IDLE, ISSUE, WAIT)
//   - OWN_IF/OWN_MEM : encoding of the requester that owns the port
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Single-port memory bus between the arbiter and the shared I/D memory.
//   Signals:
//     en     access strobe, one cycle per access
//     we     write enable, qualified by en
//     addr   access address
//     wdata  write data
//     rdata  read data, valid MEM_LAT cycles after en
//   Modports:
//     master  arbiter side (drives en/we/addr/wdata, receives rdata)
//     slave   memory side
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (
        output en,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  en,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/arb_pick2.sv
// ---------------------------------------------------------------------------
// arb_pick2
//   Two-way grant selection between the fetch (IF) and data (MEM) requesters.
//   Default build: fixed priority, MEM wins ties (it holds the older
//   instruction). With `ARB_RR_EN defined, ties go to the requester that was
//   not granted last, using the last_grant input.
//   Ports:
//     if_req, mem_req   pending requests
//     last_grant        owner of the previous grant (only with ARB_RR_EN)
//     grant_valid       at least one request is pending
//     grant_owner       OWN_IF / OWN_MEM winner, meaningful with grant_valid
//   Configuration macro: ARB_RR_EN
// ---------------------------------------------------------------------------
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic mem_req,
`ifdef ARB_RR_EN
    input  logic last_grant,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    // NOTE: every output gets a default before the branches so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid = if_req | mem_req;
        grant_owner = OWN_IF;
        if (if_req && mem_req) begin
`ifdef ARB_RR_EN
            grant_owner = ~last_grant;
`else
            grant_owner = OWN_MEM;
`endif
        end else if (mem_req) begin
            grant_owner = OWN_MEM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port instruction/data memory between the IF stage
//   (read-only fetch) and the MEM stage (load/store). One access is in
//   flight at a time: IDLE arbitrates and latches the winner, ISSUE drives a
//   one-cycle port strobe, WAIT counts down the fixed memory latency and the
//   last WAIT cycle returns data with a done pulse to the owner.
//
//   Parameters:
//     ADDR_W, DATA_W  address / data width
//     MEM_LAT         cycles from port.en to valid port.rdata (>= 1)
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     if_req/if_addr/if_flush  fetch request, address, redirect cancel
//     if_rdata/if_done/if_stall fetch result, done pulse, stall
//     mem_req/mem_we/mem_addr/mem_wdata  data request
//     mem_rdata/mem_done/mem_stall       data result, done pulse, stall
//     port                     memory bus (mem_port_arbiter_if.master)
//     busy                     an access is in progress
//   Configuration macro: ARB_RR_EN (round-robin tie break, see arb_pick2)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,

    mem_port_arbiter_if.master port,

    output logic              busy
);

    localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    generate
        if (MEM_LAT < 1) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be >= 1");
        end
    endgenerate

    arb_state_t        state;
    logic              owner;
    logic              cancel;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;

    logic              grant_valid;
    logic              grant_owner;
    logic              flush_hit;
    logic              in_issue;
    logic              done_cycle;

`ifdef ARB_RR_EN
    logic              last_grant;
`endif

    arb_pick2 u_pick (
        .if_req      (if_req),
        .mem_req     (mem_req),
`ifdef ARB_RR_EN
        .last_grant  (last_grant),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // A redirect only matters while the fetch owns the port; a flush in IDLE
    // or during a data access leaves the sequencing untouched.
    assign flush_hit = if_flush && (owner == OWN_IF);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            cancel    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
`ifdef ARB_RR_EN
            last_grant <= OWN_IF;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner  <= grant_owner;
                        cancel <= 1'b0;
                        // A fetch is always a read and carries no write data.
                        if (grant_owner == OWN_MEM) begin
                            lat_we    <= mem_we;
                            lat_addr  <= mem_addr;
                            lat_wdata <= mem_wdata;
                        end else begin
                            lat_we    <= 1'b0;
                            lat_addr  <= if_addr;
                            lat_wdata <= '0;
                        end
`ifdef ARB_RR_EN
                        last_grant <= grant_owner;
`endif
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt   <= CNT_W'(MEM_LAT - 1);
                    state <= WAIT;
                    if (flush_hit) begin
                        cancel <= 1'b1;
                    end
                end

                WAIT: begin
                    // The access always runs to completion; cancel only
                    // hides the result from the fetch stage.
                    if (flush_hit) begin
                        cancel <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_issue   = (state == ISSUE);
    assign done_cycle = (state == WAIT) && (cnt == '0);

    // Done is combinational so a flush landing in the completion cycle still
    // suppresses the fetch result.
    assign if_done  = done_cycle && (owner == OWN_IF) && !cancel && !if_flush;
    assign mem_done = done_cycle && (owner == OWN_MEM) && !cancel;

    assign if_rdata  = if_done ? port.rdata : '0;
    assign mem_rdata = (mem_done && !lat_we) ? port.rdata : '0;

    assign if_stall  = if_req  & ~if_done;
    assign mem_stall = mem_req & ~mem_done;

    assign port.en    = in_issue;
    assign port.we    = in_issue & lat_we;
    assign port.addr  = in_issue ? lat_addr  : '0;
    assign port.wdata = in_issue ? lat_wdata : '0;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Two instances share the requester
//   inputs: u_lat1 (MEM_LAT=1) and u_lat3 (MEM_LAT=3); each has its own
//   reset so the idle one can be parked while the other is exercised.
//   Each instance is attached to a small memory model that returns valid
//   read data exactly MEM_LAT cycles after the strobe and a marker word at
//   every other time. Memory word at byte address a holds 32'hC0DE_0000|a,
//   except address 0x10 which holds 32'hDEADBEEF.
//   Control outputs are compared as a 7-bit vector:
//     {if_done, if_stall, mem_done, mem_stall, busy, port.en, port.we}
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst1;
    logic        rst3;
    logic        mem_init;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic [31:0] a_if_rdata, a_mem_rdata, b_if_rdata, b_mem_rdata;
    logic        a_if_done, a_if_stall, a_mem_done, a_mem_stall, a_busy;
    logic        b_if_done, b_if_stall, b_mem_done, b_mem_stall, b_busy;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p3 ();

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
        .clk       (clk),
        .rst       (rst1),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (a_if_rdata),
        .if_done   (a_if_done),
        .if_stall  (a_if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (a_mem_rdata),
        .mem_done  (a_mem_done),
        .mem_stall (a_mem_stall),
        .port      (p1),
        .busy      (a_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
        .clk       (clk),
        .rst       (rst3),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (b_if_rdata),
        .if_done   (b_if_done),
        .if_stall  (b_if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (b_mem_rdata),
        .mem_done  (b_mem_done),
        .mem_stall (b_mem_stall),
        .port      (p3),
        .busy      (b_busy)
    );

    logic [6:0] ctrl1, ctrl3;
    assign ctrl1 = {a_if_done, a_if_stall, a_mem_done, a_mem_stall, a_busy, p1.en, p1.we};
    assign ctrl3 = {b_if_done, b_if_stall, b_mem_done, b_mem_stall, b_busy, p3.en, p3.we};

    // ---------------- memory models ----------------
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic        v1;
    logic [5:0]  a1;
    logic [2:0]  v3;
    logic [5:0]  a3 [3];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] <= (i == 4) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(i * 4));
                mem3[i] <= (i == 4) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(i * 4));
            end
        end else begin
            if (p1.en && p1.we) mem1[p1.addr[7:2]] <= p1.wdata;
            if (p3.en && p3.we) mem3[p3.addr[7:2]] <= p3.wdata;
        end
        v1    <= p1.en & ~p1.we;
        a1    <= p1.addr[7:2];
        v3    <= {v3[1:0], p3.en & ~p3.we};
        a3[0] <= p3.addr[7:2];
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end

    assign p1.rdata = v1    ? mem1[a1]    : 32'hBAD0_BAD0;
    assign p3.rdata = v3[2] ? mem3[a3[2]] : 32'hBAD0_BAD0;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = 32'h0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst1 = 1'b1;
        rst3 = 1'b1;
        mem_init = 1'b1;
        step();
        mem_init = 1'b0;
        step();
        @(negedge clk);
        vectors++;
        if (ctrl1 !== 7'b0000000) begin
            miscompares++;
            $display("FAIL reset ctrl lat1 got %b want %b", ctrl1, 7'b0000000);
        end
        vectors++;
        if (ctrl3 !== 7'b0000000) begin
            miscompares++;
            $display("FAIL reset ctrl lat3 got %b want %b", ctrl3, 7'b0000000);
        end
        vectors++;
        if ({a_if_rdata, a_mem_rdata, p1.addr, p1.wdata} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset data got %h want 0", {a_if_rdata, a_mem_rdata, p1.addr, p1.wdata});
        end
        // Stalls follow the requests even while reset is held.
        step();
        if_req  = 1'b1;
        mem_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctrl1 !== 7'b0101000) begin
            miscompares++;
            $display("FAIL reset stall ctrl got %b want %b", ctrl1, 7'b0101000);
        end
        step();
        idle_inputs();
        rst1 = 1'b0;
    endtask

    task automatic test_fetch();
        logic [6:0] exp [4] = '{7'b0100000, 7'b0100110, 7'b1000100, 7'b0000000};
        for (int c = 0; c < 4; c++) begin
            step();
            case (c)
                0: begin if_req = 1'b1; if_addr = 32'h10; end
                3: if_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            vectors++;
            if (ctrl1 !== exp[c]) begin
                miscompares++;
                $display("FAIL fetch ctrl c%0d got %b want %b", c, ctrl1, exp[c]);
            end
            if (c == 1) begin
                vectors++;
                if ({p1.addr, p1.wdata} !== {32'h10, 32'h0}) begin
                    miscompares++;
                    $display("FAIL fetch port addr/wdata got %h want %h", {p1.addr, p1.wdata}, {32'h10, 32'h0});
                end
            end
            if (c == 2) begin
                vectors++;
                if (a_if_rdata !== 32'hDEADBEEF) begin
                    miscompares++;
                    $display("FAIL fetch rdata got %h want %h", a_if_rdata, 32'hDEADBEEF);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [6:0] exp [7] = '{7'b0101000, 7'b0101111, 7'b0110100, 7'b0100000,
                                7'b0100110, 7'b1000100, 7'b0000000};
        for (int c = 0; c < 7; c++) begin
            step();
            case (c)
                0: begin
                    if_req = 1'b1; if_addr = 32'h14;
                    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h1234;
                end
                3: begin mem_req = 1'b0; mem_we = 1'b0; end
                6: if_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            vectors++;
            if (ctrl1 !== exp[c]) begin
                miscompares++;
                $display("FAIL priority ctrl c%0d got %b want %b", c, ctrl1, exp[c]);
            end
            if (c == 1) begin
                vectors++;
                if ({p1.addr, p1.wdata} !== {32'h40, 32'h1234}) begin
                    miscompares++;
                    $display("FAIL priority store port got %h want %h", {p1.addr, p1.wdata}, {32'h40, 32'h1234});
                end
            end
            if (c == 2) begin
                vectors++;
                if (a_mem_rdata !== 32'h0) begin
                    miscompares++;
                    $display("FAIL priority store rdata got %h want 0", a_mem_rdata);
                end
            end
            if (c == 4) begin
                vectors++;
                if (p1.addr !== 32'h14) begin
                    miscompares++;
                    $display("FAIL priority fetch addr got %h want %h", p1.addr, 32'h14);
                end
            end
            if (c == 5) begin
                vectors++;
                if (a_if_rdata !== 32'hC0DE_0014) begin
                    miscompares++;
                    $display("FAIL priority fetch rdata got %h want %h", a_if_rdata, 32'hC0DE_0014);
                end
            end
        end
    endtask

    task automatic test_load_after_store();
        logic [6:0] exp [4] = '{7'b0001000, 7'b0001110, 7'b0010100, 7'b0000000};
        for (int c = 0; c < 4; c++) begin
            step();
            case (c)
                0: begin mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; end
                3: mem_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            vectors++;
            if (ctrl1 !== exp[c]) begin
                miscompares++;
                $display("FAIL load ctrl c%0d got %b want %b", c, ctrl1, exp[c]);
            end
            if (c == 2) begin
                vectors++;
                if (a_mem_rdata !== 32'h1234) begin
                    miscompares++;
                    $display("FAIL load stored word got %h want %h", a_mem_rdata, 32'h1234);
                end
            end
        end
    endtask

    // Flush during ISSUE, then flush in the completion cycle.
    task automatic test_flush();
        logic [6:0] exp [7] = '{7'b0100000, 7'b0100110, 7'b0100100, 7'b0100000,
                                7'b0100110, 7'b1000100, 7'b0000000};
        logic [31:0] first_addr [2]  = '{32'h20, 32'h24};
        logic [31:0] second_addr [2] = '{32'h30, 32'h28};
        logic [31:0] exp_data [2]    = '{32'hC0DE_0030, 32'hC0DE_0028};
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 7; c++) begin
                step();
                if (c == 0) begin
                    if_req = 1'b1; if_addr = first_addr[k];
                end
                if (c == k + 1) begin
                    if_flush = 1'b1; if_addr = second_addr[k];
                end
                if (c == k + 2) if_flush = 1'b0;
                if (c == 6) if_req = 1'b0;
                @(negedge clk);
                vectors++;
                if (ctrl1 !== exp[c]) begin
                    miscompares++;
                    $display("FAIL flush%0d ctrl c%0d got %b want %b", k, c, ctrl1, exp[c]);
                end
                if (c == 1 || c == 4) begin
                    vectors++;
                    if (p1.addr !== ((c == 1) ? first_addr[k] : second_addr[k])) begin
                        miscompares++;
                        $display("FAIL flush%0d port addr c%0d got %h want %h", k, c, p1.addr,
                                 (c == 1) ? first_addr[k] : second_addr[k]);
                    end
                end
                if (c == 2) begin
                    vectors++;
                    if (a_if_rdata !== 32'h0) begin
                        miscompares++;
                        $display("FAIL flush%0d cancelled rdata got %h want 0", k, a_if_rdata);
                    end
                end
                if (c == 5) begin
                    vectors++;
                    if (a_if_rdata !== exp_data[k]) begin
                        miscompares++;
                        $display("FAIL flush%0d refetch rdata got %h want %h", k, a_if_rdata, exp_data[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_flush_mem_owner();
        logic [6:0] exp [4] = '{7'b0001000, 7'b0001110, 7'b0010100, 7'b0000000};
        for (int c = 0; c < 4; c++) begin
            step();
            case (c)
                0: begin mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h18; end
                1: if_flush = 1'b1;
                2: if_flush = 1'b0;
                3: mem_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            vectors++;
            if (ctrl1 !== exp[c]) begin
                miscompares++;
                $display("FAIL flush_mem ctrl c%0d got %b want %b", c, ctrl1, exp[c]);
            end
            if (c == 2) begin
                vectors++;
                if (a_mem_rdata !== 32'hC0DE_0018) begin
                    miscompares++;
                    $display("FAIL flush_mem rdata got %h want %h", a_mem_rdata, 32'hC0DE_0018);
                end
            end
        end
    endtask

    task automatic test_lat3();
        logic [6:0] exp [6] = '{7'b0001000, 7'b0001110, 7'b0001100, 7'b0001100,
                                7'b0010100, 7'b0000000};
        step();
        rst1 = 1'b1;
        rst3 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            case (c)
                0: begin mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h80; end
                5: mem_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            vectors++;
            if (ctrl3 !== exp[c]) begin
                miscompares++;
                $display("FAIL lat3 ctrl c%0d got %b want %b", c, ctrl3, exp[c]);
            end
            if (c == 1) begin
                vectors++;
                if (p3.addr !== 32'h80) begin
                    miscompares++;
                    $display("FAIL lat3 port addr got %h want %h", p3.addr, 32'h80);
                end
            end
            if (c == 3) begin
                vectors++;
                if (b_mem_rdata !== 32'h0) begin
                    miscompares++;
                    $display("FAIL lat3 early rdata got %h want 0", b_mem_rdata);
                end
            end
            if (c == 4) begin
                vectors++;
                if (b_mem_rdata !== 32'hC0DE_0080) begin
                    miscompares++;
                    $display("FAIL lat3 rdata got %h want %h", b_mem_rdata, 32'hC0DE_0080);
                end
            end
        end
    endtask

    task automatic test_reset_midaccess();
        logic [6:0] exp [9] = '{7'b0001000, 7'b0001110, 7'b0001100, 7'b0001000,
                                7'b0001110, 7'b0001100, 7'b0001100, 7'b0010100,
                                7'b0000000};
        for (int c = 0; c < 9; c++) begin
            step();
            case (c)
                0: begin mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h84; end
                2: rst3 = 1'b1;
                3: rst3 = 1'b0;
                8: mem_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            vectors++;
            if (ctrl3 !== exp[c]) begin
                miscompares++;
                $display("FAIL rst_mid ctrl c%0d got %b want %b", c, ctrl3, exp[c]);
            end
            if (c == 3) begin
                vectors++;
                if ({b_if_rdata, b_mem_rdata, p3.addr, p3.wdata} !== 128'h0) begin
                    miscompares++;
                    $display("FAIL rst_mid data got %h want 0", {b_if_rdata, b_mem_rdata, p3.addr, p3.wdata});
                end
            end
            if (c == 4) begin
                vectors++;
                if (p3.addr !== 32'h84) begin
                    miscompares++;
                    $display("FAIL rst_mid reissue addr got %h want %h", p3.addr, 32'h84);
                end
            end
            if (c == 7) begin
                vectors++;
                if (b_mem_rdata !== 32'hC0DE_0084) begin
                    miscompares++;
                    $display("FAIL rst_mid rdata got %h want %h", b_mem_rdata, 32'hC0DE_0084);
                end
            end
        end
    endtask

    task automatic test_back_to_back_ties();
        logic [31:0] got [$];
`ifdef ARB_RR_EN
        logic [31:0] exp [4] = '{32'h44, 32'h10, 32'h44, 32'h10};
`else
        logic [31:0] exp [4] = '{32'h44, 32'h44, 32'h44, 32'h44};
`endif
        step();
        rst3 = 1'b1;
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h10;
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h44;
            end
            @(negedge clk);
            if (p1.en) got.push_back(p1.addr);
        end
        step();
        idle_inputs();
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL ties grant count got %0d want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL ties grant %0d addr got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout after %0d vectors", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_load_after_store();
        test_flush();
        test_flush_mem_owner();
        test_lat3();
        test_reset_midaccess();
        test_back_to_back_ties();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
